mult_div_unit: RTL

//  Multi-cycle multiply/divide unit sitting beside the single-cycle ALU in the EX stage.
//  It takes In1/In2/Func operands and a start request from the pipeline.
//  It runs an iterative shift-add multiply or restoring divide and holds the result in HI/LO.
//  The pipeline stalls on busy and reads HI/LO directly for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply and restoring
// divide, one bit per clock, results held in HI/LO until the next op or MTHI/MTLO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       Func,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rneg_q;
  logic               div0_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_signed_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;

  // Operand magnitudes for signed ops, one iteration step, and final sign fix-up.
  always_comb begin
    is_signed_s = (Func == 4'd0) || (Func == 4'd2);
    mag_a_s     = (is_signed_s && In1[WIDTH-1]) ? -In1 : In1;
    mag_b_s     = (is_signed_s && In2[WIDTH-1]) ? -In2 : In2;

    // Multiply: acc = {partial high, remaining multiplier}, shifted right each step.
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_q};

    if (is_div_q) begin
      if (div_diff_s[WIDTH]) begin
        acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end

    prod_s = neg_q ? -acc_d : acc_d;
    quo_s  = acc_d[WIDTH-1:0];
    rem_s  = acc_d[2*WIDTH-1:WIDTH];

    if (is_div_q) begin
      // A zero divisor leaves |In1| as remainder; restoring its sign yields In1 itself.
      fin_lo_s = div0_q ? {WIDTH{1'b1}} : (neg_q ? -quo_s : quo_s);
      fin_hi_s = rneg_q ? -rem_s : rem_s;
    end else begin
      fin_lo_s = prod_s[WIDTH-1:0];
      fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (Func)
              4'd0, 4'd1, 4'd2, 4'd3: begin
                is_div_q <= Func[1];
                neg_q    <= is_signed_s && (In1[WIDTH-1] ^ In2[WIDTH-1]);
                rneg_q   <= is_signed_s && In1[WIDTH-1];
                div0_q   <= (In2 == {WIDTH{1'b0}});
                opb_q    <= Func[1] ? mag_b_s : mag_a_s;
                acc_q    <= {{WIDTH{1'b0}}, (Func[1] ? mag_a_s : mag_b_s)};
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              4'd4:    hi_q <= In1;
              4'd5:    lo_q <= In1;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_q == CW'(WIDTH-1)) begin
            hi_q    <= fin_hi_s;
            lo_q    <= fin_lo_s;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
